// File: rtl/icache.sv
// Direct-mapped instruction cache: one word per line, single-cycle hits, one
// outstanding fill to the memory controller on a miss.
module icache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  if2cache_en,
  input  logic [ADDR_WIDTH-1:0] if2cache_PC,
  output logic                  cache2if_ready,
  output logic                  cache2if_valid,
  output logic [INST_WIDTH-1:0] cache2if_inst,
  output logic [ADDR_WIDTH-1:0] cache2if_PC,
  output logic                  cache2mem_upd_en,
  output logic [ADDR_WIDTH-1:0] cache2mem_PC,
  input  logic                  mem_rdy,
  input  logic [INST_WIDTH-1:0] mem2cache_inst
);

  localparam int LINES = 2 ** INDEX_WIDTH;
  localparam int TW    = ADDR_WIDTH - INDEX_WIDTH - 1;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t                  r_state;
  logic [LINES-1:0]        r_valid_bits;
  logic [TW-1:0]           r_tag  [LINES];
  logic [INST_WIDTH-1:0]   r_data [LINES];
  logic                    r_if_valid;
  logic [INST_WIDTH-1:0]   r_if_inst;
  logic [ADDR_WIDTH-1:0]   r_if_pc;
  logic                    r_upd_en;
  logic [ADDR_WIDTH-1:0]   r_mem_pc;
  logic                    r_killed;

  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [TW-1:0]           w_tag;
  logic                    w_hit;
  logic [INDEX_WIDTH-1:0]  w_fill_idx;
  logic [TW-1:0]           w_fill_tag;
  logic                    w_fill;
  logic                    w_unused;

  // r_mem_pc doubles as the pending-miss PC: it is stable for the whole MISS state.
  assign w_idx      = if2cache_PC[INDEX_WIDTH:1];
  assign w_tag      = if2cache_PC[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign w_hit      = r_valid_bits[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_idx = r_mem_pc[INDEX_WIDTH:1];
  assign w_fill_tag = r_mem_pc[ADDR_WIDTH-1:INDEX_WIDTH+1];
  assign w_fill     = rdy_in && (r_state == S_MISS) && mem_rdy;
  assign w_unused   = if2cache_PC[0] ^ r_mem_pc[0];

  assign cache2if_ready   = (r_state == S_IDLE);
  assign cache2if_valid   = r_if_valid;
  assign cache2if_inst    = r_if_inst;
  assign cache2if_PC      = r_if_pc;
  assign cache2mem_upd_en = r_upd_en;
  assign cache2mem_PC     = r_mem_pc;

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem2cache_inst;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_valid_bits <= '0;
      r_if_valid   <= 1'b0;
      r_if_inst    <= '0;
      r_if_pc      <= '0;
      r_upd_en     <= 1'b0;
      r_mem_pc     <= '0;
      r_killed     <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          r_if_valid <= 1'b0;
          r_killed   <= 1'b0;
          if (if2cache_en && !clear) begin
            if (w_hit) begin
              r_if_valid <= 1'b1;
              r_if_inst  <= r_data[w_idx];
              r_if_pc    <= if2cache_PC;
            end else begin
              r_state  <= S_MISS;
              r_upd_en <= 1'b1;
              r_mem_pc <= if2cache_PC;
            end
          end
        end
        S_MISS: begin
          if (mem_rdy) begin
            r_valid_bits[w_fill_idx] <= 1'b1;
            r_upd_en   <= 1'b0;
            r_if_valid <= !(r_killed || clear);
            r_if_inst  <= mem2cache_inst;
            r_if_pc    <= r_mem_pc;
            r_state    <= S_IDLE;
            r_killed   <= 1'b0;
          end else if (clear) begin
            r_killed <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
